dct8_chen_pipe: RTL and testbench

Pipelined, back-pressurable 8-point forward 1-D DCT (Chen factorisation), the registered successor to the team's combinational 8-point DCT core.
- Accepts one 8-sample row per cycle over a valid/ready handshake.
- Keeps full bit-growth through the butterflies and saturates only at the output.
- Tags every ROWS-th row with `out_last` so a transpose buffer and a second instance can form the 2-D DCT.

---
 rtl/dct8_chen_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_dct8_chen_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dct8_chen_pipe.sv
// dct8_chen_pipe: four-stage pipelined 8-point forward 1-D DCT (Chen
// factorisation) with a valid/ready handshake. Full bit growth is kept through
// the butterflies; results saturate only at the output. Every ROWS-th accepted
// row is tagged with out_last.
// Build option: define DCT_ROUND_EN for round-half-up in every fixed-point
// multiply; left undefined, products truncate toward -inf.
module dct8_chen_pipe #(
  parameter int IN_W    = 16,
  parameter int FRAC    = 14,
  parameter int CONST_W = 16,
  parameter int ROWS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_d0,
  input  logic signed [IN_W-1:0] in_d1,
  input  logic signed [IN_W-1:0] in_d2,
  input  logic signed [IN_W-1:0] in_d3,
  input  logic signed [IN_W-1:0] in_d4,
  input  logic signed [IN_W-1:0] in_d5,
  input  logic signed [IN_W-1:0] in_d6,
  input  logic signed [IN_W-1:0] in_d7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W-1:0] out_d0,
  output logic signed [IN_W-1:0] out_d1,
  output logic signed [IN_W-1:0] out_d2,
  output logic signed [IN_W-1:0] out_d3,
  output logic signed [IN_W-1:0] out_d4,
  output logic signed [IN_W-1:0] out_d5,
  output logic signed [IN_W-1:0] out_d6,
  output logic signed [IN_W-1:0] out_d7,
  output logic                   out_last,
  output logic                   out_ovf
);

  // PW holds a raw D*c product; W is wide enough for every scaled sum.
  localparam int  PW    = IN_W + 1 + CONST_W;
  localparam int  W     = IN_W + CONST_W + 4;
  localparam int  CW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam real SCALE = real'(longint'(1) << FRAC);

  localparam logic signed [CONST_W-1:0] C1 = CONST_W'($rtoi(0.980785280403230 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] C2 = CONST_W'($rtoi(0.923879532511287 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] C3 = CONST_W'($rtoi(0.831469612302545 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] C4 = CONST_W'($rtoi(0.707106781186548 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] C6 = CONST_W'($rtoi(0.382683432365090 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] S1 = CONST_W'($rtoi(0.195090322016128 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] S3 = CONST_W'($rtoi(0.555570233019602 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K0 = CONST_W'($rtoi(0.353553390593274 * SCALE + 0.5));
  localparam logic signed [CONST_W-1:0] K  = CONST_W'($rtoi(0.5 * SCALE + 0.5));

`ifdef DCT_ROUND_EN
  localparam logic signed [W-1:0] RND = W'(longint'(1) << (FRAC - 1));
`else
  localparam logic signed [W-1:0] RND = '0;
`endif

  localparam logic signed [W-1:0] MAXV    = W'((longint'(1) << (IN_W - 1)) - 1);
  localparam logic signed [W-1:0] MINV    = -MAXV - W'(1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(ROWS - 1);

  // Column index of each odd constant within a row of stored products.
  localparam int IC1 = 0, IC3 = 1, IS1 = 2, IS3 = 3;

  function automatic logic signed [W-1:0] rs(input logic signed [W-1:0] p);
    return (p + RND) >>> FRAC;
  endfunction

  function automatic logic signed [W-1:0] mulc(input logic signed [W-1:0] a,
                                               input logic signed [CONST_W-1:0] c);
    logic signed [W-1:0] cw;
    cw = W'(c);
    return rs(a * cw);
  endfunction

  function automatic logic signed [PW-1:0] pmul(input logic signed [IN_W:0] d,
                                                input logic signed [CONST_W-1:0] c);
    logic signed [PW-1:0] dw, cw;
    dw = PW'(d);
    cw = PW'(c);
    return dw * cw;
  endfunction

  logic                   adv, acc;
  logic [CW-1:0]          cnt;
  logic                   v1, v2, v3, last1, last2, last3;
  logic signed [IN_W-1:0] x [8];
  logic signed [IN_W:0]   s_n [4], d_n [4], s1 [4], d1 [4];
  logic signed [IN_W+1:0] e0, e1, e2_n, e3_n, e2r, e3r;
  logic signed [IN_W+2:0] a_n, m_n, a2, m2;
  logic signed [PW-1:0]   od_n [4][4], od2 [4][4];
  logic signed [W-1:0]    o [4][4];
  logic signed [W-1:0]    b_n [8], b3 [8], sc [8];
  logic signed [IN_W-1:0] y_n [8], y [8];
  logic                   ovf_n;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  // Gather the input row and form the P1 butterflies.
  always_comb begin
    x[0] = in_d0; x[1] = in_d1; x[2] = in_d2; x[3] = in_d3;
    x[4] = in_d4; x[5] = in_d5; x[6] = in_d6; x[7] = in_d7;
    for (int k = 0; k < 4; k++) begin
      s_n[k] = (IN_W+1)'(x[k]) + (IN_W+1)'(x[7-k]);
      d_n[k] = (IN_W+1)'(x[k]) - (IN_W+1)'(x[7-k]);
    end
  end

  // P2: even-half butterflies and the sixteen raw odd-half products.
  always_comb begin
    e0   = (IN_W+2)'(s1[0]) + (IN_W+2)'(s1[3]);
    e1   = (IN_W+2)'(s1[1]) + (IN_W+2)'(s1[2]);
    e2_n = (IN_W+2)'(s1[0]) - (IN_W+2)'(s1[3]);
    e3_n = (IN_W+2)'(s1[1]) - (IN_W+2)'(s1[2]);
    a_n  = (IN_W+3)'(e0) + (IN_W+3)'(e1);
    m_n  = (IN_W+3)'(e0) - (IN_W+3)'(e1);
    for (int k = 0; k < 4; k++) begin
      od_n[k][IC1] = pmul(d1[k], C1);
      od_n[k][IC3] = pmul(d1[k], C3);
      od_n[k][IS1] = pmul(d1[k], S1);
      od_n[k][IS3] = pmul(d1[k], S3);
    end
  end

  // P3: rotations and odd-half sums, still unscaled.
  always_comb begin
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        o[k][j] = rs(W'(od2[k][j]));
    b_n[0] = W'(a2);
    b_n[4] = mulc(W'(m2), C4);
    b_n[2] = mulc(W'(e2r), C2) + mulc(W'(e3r), C6);
    b_n[6] = mulc(W'(e2r), C6) - mulc(W'(e3r), C2);
    b_n[1] = o[0][IC1] + o[1][IC3] + o[2][IS3] + o[3][IS1];
    b_n[3] = o[0][IC3] - o[1][IS1] - o[2][IC1] - o[3][IS3];
    b_n[5] = o[0][IS3] - o[1][IC1] + o[2][IS1] + o[3][IC3];
    b_n[7] = o[0][IS1] - o[1][IS3] + o[2][IC3] - o[3][IC1];
  end

  // P4: final scaling, clamp to the output word, flag any clamp.
  always_comb begin
    // NOTE: every variable gets a value on every path here, so no latch is inferred.
    ovf_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sc[k] = mulc(b3[k], (k == 0) ? K0 : K);
      if (sc[k] > MAXV) begin
        y_n[k] = MAXV[IN_W-1:0];
        ovf_n  = 1'b1;
      end else if (sc[k] < MINV) begin
        y_n[k] = MINV[IN_W-1:0];
        ovf_n  = 1'b1;
      end else begin
        y_n[k] = sc[k][IN_W-1:0];
      end
    end
  end

  // Control: row counter, stage-valid bits, last tags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      last3     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      for (int k = 0; k < 8; k++) y[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      if (acc) cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      if (adv) begin
        v1        <= in_valid;
        last1     <= in_valid & (cnt == CNT_MAX);
        v2        <= v1;
        last2     <= last1;
        v3        <= v2;
        last3     <= last2;
        out_valid <= v3;
        out_last  <= last3;
        out_ovf   <= ovf_n & v3;
        y         <= y_n;
      end
    end
  end

  // Datapath stage registers, advancing with the global stall.
  // NOTE: no reset here; the valid bits alone decide whether this data means anything.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1  <= s_n;
      d1  <= d_n;
      a2  <= a_n;
      m2  <= m_n;
      e2r <= e2_n;
      e3r <= e3_n;
      od2 <= od_n;
      b3  <= b_n;
    end
  end

  assign out_d0 = y[0];
  assign out_d1 = y[1];
  assign out_d2 = y[2];
  assign out_d3 = y[3];
  assign out_d4 = y[4];
  assign out_d5 = y[5];
  assign out_d6 = y[6];
  assign out_d7 = y[7];

endmodule

// File: tb/tb_dct8_chen_pipe.sv
// tb_dct8_chen_pipe: directed vectors with hand-computed coefficients
// (truncating build), plus back-pressure and mid-stream reset sequences.
module tb_dct8_chen_pipe;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                out_last;
  logic                out_ovf;
  logic signed [15:0]  id [8];
  logic signed [15:0]  od [8];

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    string name;
    int    x [8];
    int    y [8];
    bit    ovf;
  } vec_t;

  vec_t vt [7];

  always #5 clk = ~clk;

  dct8_chen_pipe #(.IN_W(16), .FRAC(14), .CONST_W(16), .ROWS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(id[0]), .in_d1(id[1]), .in_d2(id[2]), .in_d3(id[3]),
    .in_d4(id[4]), .in_d5(id[5]), .in_d6(id[6]), .in_d7(id[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(od[0]), .out_d1(od[1]), .out_d2(od[2]), .out_d3(od[3]),
    .out_d4(od[4]), .out_d5(od[5]), .out_d6(od[6]), .out_d7(od[7]),
    .out_last(out_last), .out_ovf(out_ovf)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic longint dc_x0(input int v);
    return (longint'(8 * v) * 5793) >>> 14;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, got, cyc;
    bit  stall_prev, stale;
    logic signed [15:0] hold_d0;
    logic hold_last;

    vt[0].name = "zero";  vt[0].x = '{0, 0, 0, 0, 0, 0, 0, 0};
    vt[0].y = '{0, 0, 0, 0, 0, 0, 0, 0};                vt[0].ovf = 1'b0;
    vt[1].name = "dc100"; vt[1].x = '{100, 100, 100, 100, 100, 100, 100, 100};
    vt[1].y = '{282, 0, 0, 0, 0, 0, 0, 0};              vt[1].ovf = 1'b0;
    vt[2].name = "imp_p"; vt[2].x = '{1000, 0, 0, 0, 0, 0, 0, 0};
    vt[2].y = '{353, 490, 461, 415, 353, 277, 191, 97}; vt[2].ovf = 1'b0;
    vt[3].name = "imp_n"; vt[3].x = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    vt[3].y = '{-354, -491, -462, -416, -354, -278, -192, -98}; vt[3].ovf = 1'b0;
    vt[4].name = "imp_x7"; vt[4].x = '{0, 0, 0, 0, 0, 0, 0, 1000};
    vt[4].y = '{353, -491, 461, -416, 353, -278, 191, -98}; vt[4].ovf = 1'b0;
    vt[5].name = "sat_p"; vt[5].x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    vt[5].y = '{32767, 0, 0, 0, 0, 0, 0, 0};            vt[5].ovf = 1'b1;
    vt[6].name = "sat_n"; vt[6].x = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    vt[6].y = '{-32768, 0, 0, 0, 0, 0, 0, 0};           vt[6].ovf = 1'b1;

    for (int k = 0; k < 8; k++) id[k] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_last", out_last, 0);
    check("rst.out_ovf", out_ovf, 0);
    for (int k = 0; k < 8; k++) check($sformatf("rst.out_d%0d", k), od[k], 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", in_ready, 1);

    // Table: one row each, never stalled, exact 4-cycle latency
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) id[k] = 16'(vt[i].x[k]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({vt[i].name, ".early_valid"}, out_valid, 0);
      @(negedge clk);
      check({vt[i].name, ".valid"}, out_valid, 1);
      for (int k = 0; k < 8; k++)
        check($sformatf("%s.d%0d", vt[i].name, k), od[k], vt[i].y[k]);
      check({vt[i].name, ".ovf"}, out_ovf, vt[i].ovf);
      check({vt[i].name, ".last"}, out_last, 0);
    end

    // Reset with three rows in flight
    @(negedge clk);
    in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) id[k] = 16'(50 * (r + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rstmid.pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.valid", out_valid, 0);
    check("rstmid.d0", od[0], 0);
    check("rstmid.last", out_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("rstmid.no_stale", stale, 0);

    // Back-pressure: 12 rows, out_ready pattern 1,0,0
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0;
    hold_d0 = '0; hold_last = 1'b0;
    while (got < 12 && cyc < 400) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 12);
      for (int k = 0; k < 8; k++) id[k] = 16'((sent + 1) * 100);
      #1;
      if (stall_prev) begin
        check("bp.hold_valid", out_valid, 1);
        check("bp.hold_d0", od[0], hold_d0);
        check("bp.hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp.row%0d.d0", got), od[0], dc_x0((got + 1) * 100));
        check($sformatf("bp.row%0d.d1", got), od[1], 0);
        check($sformatf("bp.row%0d.last", got), out_last, (got == 7) ? 1 : 0);
        got++;
      end
      stall_prev = out_valid && !out_ready;
      hold_d0    = od[0];
      hold_last  = out_last;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("bp.rows_received", got, 12);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("bp.no_extra", stale, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
